multi_debounce: RTL

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 94 +++++++++
 1 files changed

// File: rtl/multi_debounce.sv
// Multi-channel push-button debouncer with edge pulses and optional long-press detection.
// Long-press detection is built only when MULTI_DEBOUNCE_LONG_PRESS_EN is defined.
module multi_debounce #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int LP_W  = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pb,
    output logic [N_CH-1:0] pb_state,
    output logic [N_CH-1:0] pb_rise,
    output logic [N_CH-1:0] pb_fall,
    output logic [N_CH-1:0] pb_long
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Out-of-range parameter sets elaborate nothing extra; the block only documents the legal space.
    if (N_CH < 1 || N_CH > 32 || CNT_W < 2 || CNT_W > 24 || LP_W < 2 || LP_W > 28) begin : g_params_out_of_range
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             sync0;
        logic             sync1;
        logic             state;
        logic             rise;
        logic             fall;
        logic [CNT_W-1:0] cnt;

        // The counter only advances while the synchronised input disagrees with the debounced
        // level, so any sample agreeing with pb_state (a bounce) restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync0 <= 1'b0;
                sync1 <= 1'b0;
                state <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
                cnt   <= '0;
            end else begin
                sync0 <= pb[i];
                sync1 <= sync0;
                rise  <= 1'b0;
                fall  <= 1'b0;
                if (sync1 == state) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt   <= '0;
                    state <= ~state;
                    rise  <= ~state;
                    fall  <= state;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        assign pb_state[i] = state;
        assign pb_rise[i]  = rise;
        assign pb_fall[i]  = fall;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
        localparam logic [LP_W-1:0] LP_MAX = {LP_W{1'b1}};
        localparam logic [LP_W-1:0] LP_PRE = {{(LP_W-1){1'b1}}, 1'b0};
        localparam logic [LP_W-1:0] LP_ONE = {{(LP_W-1){1'b0}}, 1'b1};

        logic [LP_W-1:0] lp_cnt;
        logic            lng;

        // Saturating at LP_MAX keeps the pulse to one per press.
        always_ff @(posedge clk) begin
            if (rst) begin
                lp_cnt <= '0;
                lng    <= 1'b0;
            end else begin
                lng <= 1'b0;
                if (!state) begin
                    lp_cnt <= '0;
                end else if (lp_cnt != LP_MAX) begin
                    lp_cnt <= lp_cnt + LP_ONE;
                    lng    <= (lp_cnt == LP_PRE);
                end
            end
        end

        assign pb_long[i] = lng;
`else
        assign pb_long[i] = 1'b0;
`endif
    end

endmodule
